qspi_ram_responder: RTL and testbench

// Synthesizable QSPI memory responder: the target end of the ExoTiny QSPI memory bus.

---
 rtl/qspi_ram_responder_if.sv | 11 +
 rtl/qspi_ram_responder.sv | 196 +++++++++++++++++++
 tb/tb_qspi_ram_responder.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/qspi_ram_responder_if.sv
// QSPI pin bundle between a memory-bus initiator and the RAM responder.
interface qspi_ram_responder_if;
  logic       sck_i;
  logic       cs_in;
  logic [3:0] sd_i;
  logic [3:0] sd_o;
  logic [3:0] sd_oen_o;

  modport master (output sck_i, cs_in, sd_i, input sd_o, sd_oen_o);
  modport slave  (input sck_i, cs_in, sd_i, output sd_o, sd_oen_o);
endinterface

// File: rtl/qspi_ram_responder.sv
// QSPI memory responder: decodes quad read/write frames from an oversampled QSPI
// bus and serves them from an internal byte array.
//
// state  | meaning
// IDLE   | waiting for cs to fall
// CMD    | shifting 8 command bits on sd[0]
// ADDR   | shifting 6 address nibbles
// DUMMY  | counting dummy sck cycles before read data
// RD     | driving read nibbles on each sck fall
// WR     | collecting nibble pairs and writing bytes
// IGNORE | unknown command, idle until cs rises
module qspi_ram_responder #(
  parameter int         DEPTH = 1024,
  parameter int         DUMMY = 6,
  parameter logic [7:0] RDCMD = 8'hEB,
  parameter logic [7:0] WRCMD = 8'h38
) (
  input  logic                  clk_i,
  input  logic                  rst_in,
  qspi_ram_responder_if.slave   bus,
  output logic                  busy_o,
  output logic                  err_o
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE, ST_CMD, ST_ADDR, ST_DUMMY, ST_RD, ST_WR, ST_IGNORE
  } state_t;

  logic          sck_q1, sck_q2, sck_q3;
  logic          cs_q1, cs_q2, cs_q3;
  logic [3:0]    sd_q1, sd_q2;

  state_t        state;
  logic [7:0]    cnt;
  logic [7:0]    cmd_sr;
  logic [AW-1:0] addr;
  logic          is_rd;
  logic          nib_lo;
  logic          dummy_done;
  logic [3:0]    hi_nib;
  logic [3:0]    sd_r;
  logic [3:0]    oen_r;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;

  logic [7:0]    mem [DEPTH];

  logic          sck_rise, sck_fall, cs_rise, cs_fall;
  logic [7:0]    cmd_next;
  logic [7:0]    rd_byte;

  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      sck_q1 <= 1'b0; sck_q2 <= 1'b0; sck_q3 <= 1'b0;
      cs_q1  <= 1'b1; cs_q2  <= 1'b1; cs_q3  <= 1'b1;
      sd_q1  <= 4'h0; sd_q2  <= 4'h0;
    end else begin
      sck_q1 <= bus.sck_i; sck_q2 <= sck_q1; sck_q3 <= sck_q2;
      cs_q1  <= bus.cs_in; cs_q2  <= cs_q1;  cs_q3  <= cs_q2;
      sd_q1  <= bus.sd_i;  sd_q2  <= sd_q1;
    end
  end

  assign sck_rise = sck_q2 & ~sck_q3;
  assign sck_fall = ~sck_q2 & sck_q3;
  assign cs_rise  = cs_q2 & ~cs_q3;
  assign cs_fall  = ~cs_q2 & cs_q3;
  assign cmd_next = 8'({cmd_sr, sd_q2[0]});
  assign rd_byte  = mem[addr];

  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      cmd_sr     <= '0;
      addr       <= '0;
      is_rd      <= 1'b0;
      nib_lo     <= 1'b0;
      dummy_done <= 1'b0;
      hi_nib     <= '0;
      sd_r       <= '0;
      oen_r      <= '0;
      err_o      <= 1'b0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
    end else begin
      err_o <= 1'b0;
      wr_en <= 1'b0;
      // cs release outranks any sck edge seen in the same clock
      if (cs_rise) begin
        state      <= ST_IDLE;
        cnt        <= '0;
        nib_lo     <= 1'b0;
        dummy_done <= 1'b0;
        sd_r       <= '0;
        oen_r      <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (cs_fall) begin
              state  <= ST_CMD;
              cnt    <= 8'd7;
              cmd_sr <= '0;
            end
          end
          ST_CMD: begin
            if (sck_rise) begin
              cmd_sr <= cmd_next;
              if (cnt == 8'd0) begin
                if (cmd_next == RDCMD || cmd_next == WRCMD) begin
                  state <= ST_ADDR;
                  cnt   <= 8'd5;
                  is_rd <= (cmd_next == RDCMD);
                  addr  <= '0;
                end else begin
                  state <= ST_IGNORE;
                  err_o <= 1'b1;
                end
              end else begin
                cnt <= cnt - 8'd1;
              end
            end
          end
          ST_ADDR: begin
            if (sck_rise) begin
              // upper address bits shift out, leaving the address modulo DEPTH
              addr <= AW'({addr, sd_q2});
              if (cnt == 8'd0) begin
                nib_lo <= 1'b0;
                if (!is_rd) begin
                  state <= ST_WR;
                end else if (DUMMY == 0) begin
                  state <= ST_RD;
                end else begin
                  state      <= ST_DUMMY;
                  cnt        <= 8'(DUMMY - 1);
                  dummy_done <= 1'b0;
                end
              end else begin
                cnt <= cnt - 8'd1;
              end
            end
          end
          ST_DUMMY: begin
            if (sck_rise && !dummy_done) begin
              if (cnt == 8'd0) dummy_done <= 1'b1;
              else             cnt <= cnt - 8'd1;
            end else if (sck_fall && dummy_done) begin
              state  <= ST_RD;
              oen_r  <= 4'hF;
              sd_r   <= rd_byte[7:4];
              nib_lo <= 1'b1;
            end
          end
          ST_RD: begin
            if (sck_fall) begin
              oen_r  <= 4'hF;
              sd_r   <= nib_lo ? rd_byte[3:0] : rd_byte[7:4];
              nib_lo <= ~nib_lo;
              if (nib_lo) addr <= addr + AW'(1);
            end
          end
          ST_WR: begin
            if (sck_rise) begin
              if (!nib_lo) begin
                hi_nib <= sd_q2;
                nib_lo <= 1'b1;
              end else begin
                wr_en   <= 1'b1;
                wr_addr <= addr;
                wr_data <= {hi_nib, sd_q2};
                addr    <= addr + AW'(1);
                nib_lo  <= 1'b0;
              end
            end
          end
          ST_IGNORE: ;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign busy_o       = (state != ST_IDLE);
  assign bus.sd_o     = sd_r;
  assign bus.sd_oen_o = oen_r;

endmodule

// File: tb/tb_qspi_ram_responder.sv
// Scoreboarded bench for qspi_ram_responder: directed frames plus random bursts
// checked against a byte-array reference model.
module tb_qspi_ram_responder;
  localparam int DEPTH = 1024;
  localparam int DUMMY = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy, err;

  always #5 clk = ~clk;

  qspi_ram_responder_if bus ();

  qspi_ram_responder #(.DEPTH(DEPTH), .DUMMY(DUMMY)) dut (
    .clk_i  (clk),
    .rst_in (rst_n),
    .bus    (bus),
    .busy_o (busy),
    .err_o  (err)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] model [DEPTH];
  bit         known [DEPTH];
  logic [7:0] wdata [$];
  logic [4:0] exp_q [$];
  bit         exp_drive = 1'b0;
  int         err_seen = 0, err_exp = 0, err_run = 0;
  logic [4:0] mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: compares whatever the responder presents at each initiator sample point
  always @(posedge bus.sck_i) begin
    check("oen", bus.sd_oen_o, exp_drive ? 4'hF : 4'h0);
    if (bus.sd_oen_o == 4'hF) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL rd_nibble actual=%0h expected=none", bus.sd_o);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e[4]) check("rd_nibble", bus.sd_o, mon_e[3:0]);
      end
    end
  end

  always @(negedge clk) begin
    if (err === 1'b1) begin
      err_run++;
      if (err_run == 1) err_seen++;
    end else begin
      if (err_run != 0) check("err_width", err_run, 1);
      err_run = 0;
    end
  end

  task automatic sck_cycle(input logic [3:0] d);
    bus.sd_i = d;
    #40 bus.sck_i = 1'b1;
    #40 bus.sck_i = 1'b0;
  endtask

  task automatic cs_low();
    @(negedge clk);
    bus.cs_in = 1'b0;
    #40;
  endtask

  task automatic cs_high();
    #40 bus.cs_in = 1'b1;
    #80;
  endtask

  task automatic send_hdr(input logic [7:0] cmd, input logic [23:0] a);
    for (int i = 7; i >= 0; i--) sck_cycle({3'b000, cmd[i]});
    for (int i = 5; i >= 0; i--) sck_cycle(a[i*4 +: 4]);
  endtask

  task automatic wr_frame(input logic [23:0] a);
    int idx;
    cs_low();
    send_hdr(8'h38, a);
    for (int i = 0; i < wdata.size(); i++) begin
      idx = (int'(a) + i) % DEPTH;
      sck_cycle(wdata[i][7:4]);
      sck_cycle(wdata[i][3:0]);
      model[idx] = wdata[i];
      known[idx] = 1'b1;
    end
    cs_high();
    wdata.delete();
  endtask

  task automatic rd_frame(input logic [23:0] a, input int nbytes, input bit close);
    int idx;
    cs_low();
    send_hdr(8'hEB, a);
    repeat (DUMMY) sck_cycle(4'h0);
    exp_drive = 1'b1;
    for (int i = 0; i < nbytes; i++) begin
      idx = (int'(a) + i) % DEPTH;
      exp_q.push_back({known[idx], model[idx][7:4]});
      sck_cycle($urandom_range(0, 15));
      exp_q.push_back({known[idx], model[idx][3:0]});
      sck_cycle($urandom_range(0, 15));
    end
    if (close) begin
      cs_high();
      exp_drive = 1'b0;
      check("queue_drained", exp_q.size(), 0);
    end
  endtask

  initial begin
    logic [23:0] a;
    int          n;

    bus.sck_i = 1'b0;
    bus.cs_in = 1'b1;
    bus.sd_i  = 4'h0;
    for (int i = 0; i < DEPTH; i++) known[i] = 1'b0;

    #23;
    check("rst_sd_o", bus.sd_o, 0);
    check("rst_oen", bus.sd_oen_o, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    @(negedge clk) rst_n = 1'b1;
    #40;

    // basic write then read back at 0x10
    wdata = '{8'hA5, 8'h3C};
    wr_frame(24'h000010);
    rd_frame(24'h000010, 2, 1'b1);

    // write across the top of memory wraps to 0
    wdata = '{8'h11, 8'h22};
    wr_frame(24'(DEPTH - 1));
    rd_frame(24'(DEPTH - 1), 2, 1'b1);
    rd_frame(24'h000000, 1, 1'b1);

    // unknown command: one error pulse, no drive, then a normal frame
    cs_low();
    send_hdr(8'h9F, 24'h000010);
    repeat (4) sck_cycle(4'h5);
    err_exp++;
    cs_high();
    check("err_count", err_seen, err_exp);
    rd_frame(24'h000010, 2, 1'b1);

    // write aborted after a single data nibble leaves the byte untouched
    wdata = '{8'h77};
    wr_frame(24'h000020);
    cs_low();
    send_hdr(8'h38, 24'h000020);
    sck_cycle(4'h9);
    @(negedge clk);
    check("busy_before_abort", busy, 1);
    bus.cs_in = 1'b1;
    repeat (3) @(posedge clk);
    #1 check("busy_after_abort", busy, 0);
    #80;
    rd_frame(24'h000020, 1, 1'b1);

    // async reset in the middle of a read burst
    rd_frame(24'h000010, 1, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_oen", bus.sd_oen_o, 0);
    check("rst_mid_busy", busy, 0);
    exp_drive = 1'b0;
    exp_q.delete();
    bus.cs_in = 1'b1;
    #100;
    @(negedge clk) rst_n = 1'b1;
    #40;
    rd_frame(24'h000010, 2, 1'b1);

    // high address bits are ignored (0x123456 -> 0x056)
    wdata = '{8'hC7, 8'h1E};
    wr_frame(24'h123456);
    rd_frame(24'h000056, 2, 1'b1);
    rd_frame(24'hABCC56, 1, 1'b1);

    // preload a region straddling the wrap point, then random traffic
    for (int i = 0; i < 64; i++) wdata.push_back(8'($urandom));
    wr_frame(24'(DEPTH - 32));
    for (int t = 0; t < 24; t++) begin
      a = (24'($urandom) & 24'hFFFC00) | 24'((DEPTH - 32 + $urandom_range(0, 58)) % DEPTH);
      n = $urandom_range(1, 5);
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i < n; i++) wdata.push_back(8'($urandom));
        wr_frame(a);
      end else begin
        rd_frame(a, n, 1'b1);
      end
    end

    check("err_total", err_seen, err_exp);
    check("queue_final", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
